// File: rtl/add_share_pkg.sv
// Shared constants, result layout and round-robin pointer helper for add_share_sched.
// Pure declarations; no logic.
package add_share_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 8;
    localparam int IDW_DEF  = 2;

    // Result layout at the default configuration; the top builds the same shape from its own parameters.
    typedef struct packed {
        logic [IDW_DEF-1:0] id;
        logic               carry;
        logic [W_DEF-1:0]   sum;
    } result_t;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
        return (ptr + 1 >= nreq) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/add_share_sched_rr_arbiter.sv
// Round-robin grant search starting at ptr and rising modulo NREQ; purely combinational.
// Zero latency; en low forces every grant low.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any_gnt
);

    always_comb begin : search
        logic [IDW-1:0] j;
        gnt     = '0;
        idx     = '0;
        any_gnt = 1'b0;
        j       = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = IDW'((32'(ptr) + k) % NREQ);
            if (en && !any_gnt && req[j]) begin
                any_gnt = 1'b1;
                gnt[j]  = 1'b1;
                idx     = j;
            end
        end
    end

endmodule

// File: rtl/add_share_sched.sv
// Time-shares one W-bit adder among NREQ requesters with round-robin grant; ADD_SHARE_SATURATE_EN clamps on carry.
// One cycle from accept to out_valid; a stalled output (out_valid && !out_ready) blocks all grants and holds ptr.
module add_share_sched
    import add_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_sum,
    output logic              out_carry,
    output logic [IDW-1:0]    out_id,
    output logic [7:0]        busy_cnt
);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           carry;
        logic [W-1:0]   sum;
    } res_t;

    res_t           res_q, res_d;
    logic           out_valid_q, out_valid_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [7:0]     busy_cnt_q, busy_cnt_d;

    logic           slot_free;
    logic           any_gnt;
    logic [IDW-1:0] g_idx;
    logic [W-1:0]   a_sel, b_sel;
    logic [W:0]     sum_full;

    assign slot_free = !out_valid_q || out_ready;

    // rst_n gates the search so no requester sees ready while the block is held in reset.
    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (slot_free && rst_n),
        .gnt     (req_ready),
        .idx     (g_idx),
        .any_gnt (any_gnt)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                a_sel = a_sel | req_a[i*W +: W];
                b_sel = b_sel | req_b[i*W +: W];
            end
        end
        sum_full = {1'b0, a_sel} + {1'b0, b_sel};
    end

    always_comb begin
        res_d       = res_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        busy_cnt_d  = busy_cnt_q + ((out_valid_q && out_ready) ? 8'd1 : 8'd0);
        if (any_gnt) begin
            res_d.id    = g_idx;
            res_d.carry = sum_full[W];
`ifdef ADD_SHARE_SATURATE_EN
            res_d.sum   = sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];
`else
            res_d.sum   = sum_full[W-1:0];
`endif
            out_valid_d = 1'b1;
            ptr_d       = IDW'(rr_next(32'(g_idx), NREQ));
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q       <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
            busy_cnt_q  <= '0;
        end else begin
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = res_q.sum;
    assign out_carry = res_q.carry;
    assign out_id    = res_q.id;
    assign busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_add_share_sched.sv
// Directed bench for add_share_sched: expected results queued at issue time, checked by an output monitor.
module tb_add_share_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_sum;
    logic        out_carry;
    logic [1:0]  out_id;
    logic [7:0]  busy_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [10:0] sb[$];

    add_share_sched #(.NREQ(4), .W(8), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_id    (out_id),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef ADD_SHARE_SATURATE_EN
        if (s[8]) s[7:0] = 8'hFF;
`endif
        return s;
    endfunction

    // Every delivered result must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {21'd0, out_id, out_carry, out_sum}, 32'hFFFF_FFFF);
            end else begin
                chk("result", {21'd0, out_id, out_carry, out_sum}, {21'd0, sb.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    initial begin
        logic [7:0] la;
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy_cnt", {24'd0, busy_cnt}, 32'd0);
        chk("rst_out_sum", {24'd0, out_sum}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Single requester
        set_req(0, 8'h12, 8'h34);
        req_valid = 4'b0001;
        out_ready = 1'b1;
        #1 chk("single_ready", {28'd0, req_ready}, 32'h1);
        sb.push_back({2'd0, 1'b0, 8'h46});
        tick();
        req_valid = 4'b0000;
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_sum", {23'd0, out_carry, out_sum}, 32'h046);
        tick();
        chk("single_drained", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset with a pending result
        out_ready = 1'b0;
        set_req(2, 8'h01, 8'h02);
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        chk("pend_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_busy_cnt", {24'd0, busy_cnt}, 32'd0);
        req_valid = 4'b1111;
        #1 chk("async_req_ready", {28'd0, req_ready}, 32'd0);
        req_valid = 4'b0000;
        @(negedge clk) rst_n = 1'b1;

        // Fairness: all four held valid
        for (int i = 0; i < 4; i++) set_req(i, 8'(8'h10 * (i + 1)), 8'(i + 1));
        sb.push_back({2'd0, 1'b0, 8'h11});
        sb.push_back({2'd1, 1'b0, 8'h22});
        sb.push_back({2'd2, 1'b0, 8'h33});
        sb.push_back({2'd3, 1'b0, 8'h44});
        sb.push_back({2'd0, 1'b0, 8'h11});
        out_ready = 1'b1;
        req_valid = 4'b1111;
        repeat (5) tick();
        req_valid = 4'b0000;
        tick();
        chk("fair_busy_cnt", {24'd0, busy_cnt}, 32'd5);

        // Back-pressure; ptr is now 1
        out_ready = 1'b0;
        set_req(1, 8'h05, 8'h06);
        set_req(2, 8'h07, 8'h08);
        sb.push_back({2'd1, 1'b0, 8'h0B});
        req_valid = 4'b0110;
        tick();
        req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            chk("stall_ready", {28'd0, req_ready}, 32'd0);
            chk("stall_sum", {22'd0, out_id, out_sum}, {22'd1, 8'h0B});
            tick();
        end
        out_ready = 1'b1;
        sb.push_back({2'd2, 1'b0, 8'h0F});
        #1 chk("drain_grant", {28'd0, req_ready}, 32'h4);
        tick();
        req_valid = 4'b0000;
        chk("bp_next_id", {29'd0, out_valid, out_id}, 32'h6);
        tick();
        chk("bp_busy_cnt", {24'd0, busy_cnt}, 32'd7);

        // Carry (ptr is now 3)
        set_req(3, 8'hF0, 8'h20);
`ifdef ADD_SHARE_SATURATE_EN
        sb.push_back({2'd3, 1'b1, 8'hFF});
`else
        sb.push_back({2'd3, 1'b1, 8'h10});
`endif
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b0000;
        tick();
        chk("carry_busy_cnt", {24'd0, busy_cnt}, 32'd8);

        // busy_cnt wrap: 248 more deliveries bring the total to 256
        req_valid = 4'b0001;
        for (int n = 0; n < 248; n++) begin
            la = 8'(n);
            set_req(0, la, 8'h80);
            sb.push_back({2'd0, model(la, 8'h80)});
            tick();
        end
        req_valid = 4'b0000;
        chk("cnt_255", {24'd0, busy_cnt}, 32'd255);
        tick();
        chk("cnt_wrap", {24'd0, busy_cnt}, 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/add_share_sched.md
Name: add_share_sched

Overview:
- Round-robin scheduler that time-shares one W-bit adder datapath among NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one requester per cycle, registers the sum, carry and requester ID, and presents them on a single output channel with valid/ready back-pressure.
- It sits between the tile's input-decoding logic and the output pin mux.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, operand/result width in bits
- IDW, 2, width of the requester ID field; must equal clog2(NREQ)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  bit i set: requester i presents operands
- req_a  in  NREQ*W  operand A, packed; requester i at [i*W +: W]
- req_b  in  NREQ*W  operand B, packed as req_a
- req_ready  out  NREQ  one-hot accept strobe for requester i
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer takes the result when high with out_valid
- out_sum  out  W  registered sum
- out_carry  out  1  registered carry-out (overflow flag when SATURATE_EN is defined)
- out_id  out  IDW  index of the requester that produced the result
- busy_cnt  out  8  number of results delivered since reset; wraps at 255

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: out_valid=0, out_sum=0, out_carry=0, out_id=0, busy_cnt=0, round-robin pointer ptr=0. req_ready is combinational and is 0 during reset.
- slot_free = !out_valid | out_ready.
- Grant (combinational): if slot_free, search req_valid starting at index ptr and rising modulo NREQ. The first set bit g gets req_ready[g]=1. All other req_ready bits are 0. If slot_free=0, all req_ready bits are 0.
- Accept: on a rising clk edge with a grant:
  - {out_carry,out_sum} <= req_a[g] + req_b[g] as a (W+1)-bit add.
  - out_id <= g; out_valid <= 1; ptr <= (g+1) mod NREQ.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 result per cycle when out_ready is held high.
- Drain: out_valid && out_ready with no new grant -> out_valid <= 0 next edge. out_sum, out_carry and out_id hold their last values.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one. out_valid stays 1 and busy_cnt increments.
- Stall: out_valid && !out_ready -> result registers and ptr hold. No req_ready is asserted. Requesters must hold req_a, req_b and req_valid stable until granted.
- ptr advances only on an accept. Idle cycles never move it.
- busy_cnt increments on each out_valid && out_ready cycle; wraps 255 -> 0.
- req_valid deasserted before grant: allowed. Nothing is recorded.
- Reset mid-operation: a pending result is discarded immediately (asynchronously) and ptr returns to 0.
- Sum arithmetic is modulo 2^W; the carry is the bit-W result.

Optional Feature:
- Macro: ADD_SHARE_SATURATE_EN.
- Defined: if the carry is set, out_sum <= all ones (2^W-1) and out_carry=1 flags saturation.
- Undefined: wrapping sum as described in Behaviour; out_carry is the raw carry.
- The handshake and timing are identical in both builds.

Decomposition:
- Package add_share_pkg:
  - default constants NREQ_DEF=4 and W_DEF=8
  - typedef result_t, a struct of {id, carry, sum}
  - function rr_next(ptr) returning the next pointer
- Sub-module rr_arbiter (params NREQ, IDW):
  - inputs: request vector, ptr, enable
  - outputs: one-hot grant, encoded index g, any_grant
  - purely combinational
- The top level holds ptr, the result register, the adder and busy_cnt.

Test Plan:
1. Reset: apply rst_n=0 mid-cycle with out_valid=1 -> out_valid=0, busy_cnt=0 and req_ready=0 immediately, without waiting for a clock edge.
2. Single requester:
   - Stimulus: req_valid=0001, a0=0x12, b0=0x34, out_ready=1.
   - Response: next cycle out_sum=0x46, carry=0, id=0, out_valid=1.
3. Fairness:
   - Stimulus: all four requesters held valid, out_ready=1.
   - Response: out_id sequence 0,1,2,3,0 over five consecutive cycles; busy_cnt=5.
4. Back-pressure:
   - Stimulus: out_ready=0 with req_valid=0110.
   - Response: one accept (id=1), then req_ready=0 and out_sum held for 3 cycles.
   - On out_ready=1, id=2 is granted in the same cycle the id=1 result drains.
5. Carry:
   - Stimulus: a=0xF0, b=0x20.
   - Response without the macro: sum=0x10, carry=1.
   - Response with ADD_SHARE_SATURATE_EN: sum=0xFF, carry=1.
6. busy_cnt wrap: deliver 256 results -> busy_cnt reads 0.
